// File: rtl/morse_keyer_ctrl_pkg.sv
// Shared state encoding, code-format fields and interval lengths for the Morse keyer.
package morse_keyer_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StMark,
      StEgap,
      StCgap,
      StWgap
   } state_t;

   // Code word layout: length in the top three bits, elements right-aligned below.
   localparam int unsigned LEN_MSB     = 15;
   localparam int unsigned LEN_LSB     = 13;
   localparam logic [2:0]  LEN_INVALID = 3'd7;

   // Interval lengths in Morse units.
   localparam logic [2:0] DOT_U  = 3'd1;
   localparam logic [2:0] DASH_U = 3'd3;
   localparam logic [2:0] EGAP_U = 3'd1;
   localparam logic [2:0] CGAP_U = 3'd3;
   localparam logic [2:0] WGAP_U = 3'd7;

   function automatic logic [2:0] code_len(input logic [15:0] code);
      return code[LEN_MSB:LEN_LSB];
   endfunction

endpackage

// File: rtl/morse_keyer_ctrl_unit_timer.sv
// Counts whole Morse units; flags the last clock of an interval of 'units' units.
module morse_keyer_ctrl_unit_timer #(
   parameter int unsigned UNIT_CYCLES = 6000000,
   parameter int unsigned CNT_W       = 23
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       clear,
   input  logic [2:0] units,
   output logic       unit_tick,
   output logic       interval_done
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(UNIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       unit_q;

   assign unit_tick     = (cnt_q == CntLast);
   assign interval_done = unit_tick && (unit_q == units - 3'd1);

   // Cycle and unit counters; clear restarts both so intervals never inherit a partial unit.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cnt_q  <= '0;
         unit_q <= '0;
      end else if (clear) begin
         cnt_q  <= '0;
         unit_q <= '0;
      end else if (unit_tick) begin
         cnt_q  <= '0;
         unit_q <= unit_q + 3'd1;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Takes a byte from uart_rx, looks up its Morse code and keys it out with unit timing.
module morse_keyer_ctrl
   import morse_keyer_ctrl_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 6000000,
   parameter int unsigned CNT_W       = 23
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data,
   output logic        rx_ack,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        key_out,
   output logic        busy,
   output logic [15:0] cur_code,
   output logic        char_done
);

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  rom_addr_q;
   logic [15:0] cur_code_q;
   logic        key_q;
   logic [2:0]  units;
   logic        clear;
   logic        interval_done;
   logic        unit_tick_unused;  // available for debug; playback only needs interval_done
   logic [2:0]  len;

   assign len = code_len(rom_data);

   morse_keyer_ctrl_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk           (clk),
      .rst_l         (rst_l),
      .clear         (clear),
      .units         (units),
      .unit_tick     (unit_tick_unused),
      .interval_done (interval_done)
   );

   // Next-state, element index and handshake/strobe outputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      units     = DOT_U;
      rx_ack    = 1'b0;
      char_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_ready) state_d = StFetch;
         end
         StFetch: state_d = StLatch;
         StLatch: begin
            rx_ack = 1'b1;
            idx_d  = len - 3'd1;
            if (len == LEN_INVALID)  state_d = StIdle;
            else if (len == 3'd0)    state_d = StWgap;
            else                     state_d = StMark;
         end
         StMark: begin
            units = cur_code_q[idx_q] ? DASH_U : DOT_U;
            if (interval_done) state_d = (idx_q == 3'd0) ? StCgap : StEgap;
         end
         StEgap: begin
            units = EGAP_U;
            if (interval_done) begin
               idx_d   = idx_q - 3'd1;
               state_d = StMark;
            end
         end
         StCgap: begin
            units = CGAP_U;
            if (interval_done) begin
               char_done = 1'b1;
               state_d   = StIdle;
            end
         end
         StWgap: begin
            units = WGAP_U;
            if (interval_done) begin
               char_done = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Every state change restarts the unit timer.
   assign clear = (state_d != state_q);

   // State, index, ROM address, latched code and registered key drive.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         rom_addr_q <= '0;
         cur_code_q <= '0;
         key_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         key_q   <= (state_d == StMark);
         if (state_q == StIdle && rx_ready) rom_addr_q <= rx_data;
         if (state_q == StLatch)            cur_code_q <= rom_data;
      end
   end

   assign rom_addr = rom_addr_q;
   assign cur_code = cur_code_q;
   assign key_out  = key_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Scoreboard bench: per-cycle expected {key, ack, done, busy} queued per character.
module tb_morse_keyer_ctrl;

   localparam int U = 4;

   typedef struct packed {
      logic key;
      logic ack;
      logic done;
      logic busy;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        rx_ack;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        key_out;
   logic        busy;
   logic [15:0] cur_code;
   logic        char_done;

   int n_tests = 0;
   int n_fail  = 0;

   obs_t       exp_q[$];
   logic [7:0] byte_q[$];

   morse_keyer_ctrl #(
      .UNIT_CYCLES (U),
      .CNT_W       (3)
   ) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_ack    (rx_ack),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .key_out   (key_out),
      .busy      (busy),
      .cur_code  (cur_code),
      .char_done (char_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_fn(input logic [7:0] a);
      case (a)
         8'h45:   return 16'h2000;  // E
         8'h41:   return 16'h4001;  // A
         8'h54:   return 16'h2001;  // T
         8'h20:   return 16'h0000;  // space
         8'h7F:   return 16'hE000;  // invalid
         default: return 16'h0000;
      endcase
   endfunction

   // Synchronous ROM, one cycle latency.
   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   function automatic obs_t mk(input logic k, input logic a, input logic d, input logic b);
      obs_t o;
      o.key = k; o.ack = a; o.done = d; o.busy = b;
      return o;
   endfunction

   // Expected cycles from FETCH through the IDLE cycle that follows the character.
   task automatic push_char(input logic [15:0] code);
      int len;
      int mk_u;
      len = int'(code[15:13]);
      exp_q.push_back(mk(0, 0, 0, 1));
      exp_q.push_back(mk(0, 1, 0, 1));
      if (len == 0) begin
         repeat (7 * U - 1) exp_q.push_back(mk(0, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 1, 1));
      end else if (len != 7) begin
         for (int el = len - 1; el >= 0; el--) begin
            mk_u = code[el] ? 3 : 1;
            repeat (mk_u * U) exp_q.push_back(mk(1, 0, 0, 1));
            if (el > 0) repeat (U) exp_q.push_back(mk(0, 0, 0, 1));
         end
         repeat (3 * U - 1) exp_q.push_back(mk(0, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 1, 1));
      end
      exp_q.push_back(mk(0, 0, 0, 0));
   endtask

   // Advance one cycle, sample outputs, and play the uart_rx side of the handshake.
   task automatic step(output obs_t o);
      @(negedge clk);
      o = mk(key_out, rx_ack, char_done, busy);
      if (rx_ack) begin
         if (byte_q.size() > 0) rx_data = byte_q.pop_front();
         else rx_ready = 1'b0;
      end
   endtask

   task automatic start(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst_l = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
      #3;
      n_tests++;
      if ({key_out, rx_ack, busy, char_done} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0000", {key_out, rx_ack, busy, char_done});
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (rom_addr !== 8'h00 || cur_code !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_regs: rom_addr %h cur_code %h want 00 0000", rom_addr, cur_code);
      end
      rst_l = 1'b1;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || key_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: busy %b key %b want 0 0", busy, key_out);
      end
   endtask

   task automatic test_dot_e;
      obs_t o, e;
      int c = 0;
      start(8'h45);
      push_char(16'h2000);
      while (exp_q.size() > 0) begin
         step(o);
         e = exp_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL dot_e cyc %0d: key/ack/done/busy got %b want %b", c, o, e);
         end
         c++;
      end
      n_tests++;
      if (rom_addr !== 8'h45) begin
         n_fail++;
         $display("FAIL dot_e_rom_addr: got %h want 45", rom_addr);
      end
   endtask

   task automatic test_dot_dash_a;
      obs_t o, e;
      int c = 0;
      start(8'h41);
      push_char(16'h4001);
      while (exp_q.size() > 0) begin
         step(o);
         e = exp_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL dot_dash_a cyc %0d: key/ack/done/busy got %b want %b", c, o, e);
         end
         if (c >= 2) begin
            n_tests++;
            if (cur_code !== 16'h4001) begin
               n_fail++;
               $display("FAIL dot_dash_a_cur_code cyc %0d: got %h want 4001", c, cur_code);
            end
         end
         c++;
      end
   endtask

   task automatic test_word_space;
      obs_t o, e;
      int c = 0;
      start(8'h20);
      push_char(16'h0000);
      while (exp_q.size() > 0) begin
         step(o);
         e = exp_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL word_space cyc %0d: key/ack/done/busy got %b want %b", c, o, e);
         end
         c++;
      end
   endtask

   task automatic test_invalid;
      obs_t o, e;
      int c = 0;
      start(8'h7F);
      push_char(16'hE000);
      // Extra quiet cycles: no late key or char_done may appear.
      repeat (8) exp_q.push_back(mk(0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         step(o);
         e = exp_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL invalid cyc %0d: key/ack/done/busy got %b want %b", c, o, e);
         end
         c++;
      end
   endtask

   task automatic test_back_to_back;
      obs_t o, e;
      int c = 0;
      int acks = 0;
      byte_q.push_back(8'h45);
      start(8'h54);
      push_char(16'h2001);
      push_char(16'h2000);
      while (exp_q.size() > 0) begin
         step(o);
         e = exp_q.pop_front();
         if (o.ack) acks++;
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL back_to_back cyc %0d: key/ack/done/busy got %b want %b", c, o, e);
         end
         c++;
      end
      n_tests++;
      if (acks != 2) begin
         n_fail++;
         $display("FAIL back_to_back_ack_count: got %0d want 2", acks);
      end
   endtask

   task automatic test_reset_mid_dash;
      obs_t o, e;
      int c = 0;
      start(8'h54);
      push_char(16'h2001);
      // Indices 2.. are key-high cycles; index 6 is the fifth one.
      while (c <= 6) begin
         step(o);
         e = exp_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mid_dash_pre cyc %0d: key/ack/done/busy got %b want %b", c, o, e);
         end
         c++;
      end
      exp_q.delete();
      #2 rst_l = 1'b0;
      #1;
      n_tests++;
      if ({key_out, busy, rx_ack} !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_dash_async_reset: key/busy/ack got %b want 000",
                  {key_out, busy, rx_ack});
      end
      rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || cur_code !== 16'h0000) begin
         n_fail++;
         $display("FAIL mid_dash_post_idle: busy %b cur_code %h want 0 0000", busy, cur_code);
      end
      c = 0;
      start(8'h41);
      push_char(16'h4001);
      while (exp_q.size() > 0) begin
         step(o);
         e = exp_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mid_dash_replay cyc %0d: key/ack/done/busy got %b want %b", c, o, e);
         end
         c++;
      end
   endtask

   initial begin
      test_reset();
      test_dot_e();
      test_dot_dash_a();
      test_word_space();
      test_invalid();
      test_back_to_back();
      test_reset_mid_dash();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
